// File: rtl/adc_pkg.sv
// Shared definitions for the 3-wire serial ADC link (reader and emulator).
package adc_pkg;

    localparam int unsigned ADC_DATA_WIDTH = 12;
    localparam int unsigned ADC_LEAD_ZEROS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } adc_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input plus one edge-detect
// register; rise_c/fall_c are single-cycle strobes in the clk domain.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
            last_q <= RESET_VALUE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        rise_c = sync_q[SYNC_STAGES-1] & ~last_q;
        fall_c = ~sync_q[SYNC_STAGES-1] & last_q;
    end

endmodule

// File: rtl/adc_spi_emulator.sv
// Emulates the 12-bit serial ADC behind the reader's cs/sclk/sdo link.
// Optional frame statistics are enabled with ADC_SPI_EMULATOR_STATS_EN.
module adc_spi_emulator
    import adc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = ADC_DATA_WIDTH,
    parameter int unsigned LEAD_ZEROS  = ADC_LEAD_ZEROS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sample_value,
    input  logic                  sample_load,
    input  logic                  cs,
    input  logic                  sclk,
    output logic                  sdo,
    output logic                  sdo_oe,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort
`ifdef ADC_SPI_EMULATOR_STATS_EN
    ,
    output logic [15:0]           done_count,
    output logic [15:0]           abort_count
`endif
);

    localparam int unsigned FRAME_LEN = LEAD_ZEROS + DATA_WIDTH;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN);

    logic cs_rise_c;
    logic cs_fall_c;
    logic sclk_fall_c;
    logic unused_sclk_rise;

    adc_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [FRAME_LEN-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sdo_d, oe_d, busy_d, done_d, abort_d;

    // cs resets to "asserted" so a cs held low through reset is not seen as a new fall.
    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b0)
    ) u_cs_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (cs),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_sclk_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (sclk),
        .rise_c (unused_sclk_rise),
        .fall_c (sclk_fall_c)
    );

    // Holding register; the frame image is taken from its registered value at cs fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else if (sample_load) begin
            hold_q <= sample_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            sdo         <= 1'b0;
            sdo_oe      <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            sdo         <= sdo_d;
            sdo_oe      <= oe_d;
            busy        <= busy_d;
            frame_done  <= done_d;
            frame_abort <= abort_d;
        end
    end

    // Frame sequencing; cs rise takes priority over a coincident sclk fall.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        sdo_d   = sdo;
        oe_d    = sdo_oe;
        busy_d  = busy;
        done_d  = 1'b0;
        abort_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall_c) begin
                    shift_d = FRAME_LEN'(hold_q);
                    sdo_d   = shift_d[FRAME_LEN-1];
                    oe_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise_c) begin
                    abort_d = 1'b1;
                    sdo_d   = 1'b0;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sclk_fall_c) begin
                    shift_d = shift_q << 1;
                    sdo_d   = shift_q[FRAME_LEN-2];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_LEN - 2)) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (cs_rise_c) begin
                    done_d  = 1'b1;
                    sdo_d   = 1'b0;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sclk_fall_c) begin
                    sdo_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef ADC_SPI_EMULATOR_STATS_EN
    // Saturating frame counters, stepping with the done/abort pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_count  <= '0;
            abort_count <= '0;
        end else begin
            if (done_d && (done_count != 16'hFFFF)) begin
                done_count <= done_count + 16'd1;
            end
            if (abort_d && (abort_count != 16'hFFFF)) begin
                abort_count <= abort_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_spi_emulator.sv
// Bench acting as the ADC reader: table vectors, corner sequences and random frames.
module tb_adc_spi_emulator;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] sample_value;
    logic        sample_load;
    logic        cs;
    logic        sclk;
    logic        sdo;
    logic        sdo_oe;
    logic        busy;
    logic        frame_done;
    logic        frame_abort;
`ifdef ADC_SPI_EMULATOR_STATS_EN
    logic [15:0] done_count;
    logic [15:0] abort_count;
`endif

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int abort_pulses = 0;
    logic [11:0] hold_m;

    adc_spi_emulator dut (
        .clk          (clk),
        .reset        (reset),
        .sample_value (sample_value),
        .sample_load  (sample_load),
        .cs           (cs),
        .sclk         (sclk),
        .sdo          (sdo),
        .sdo_oe       (sdo_oe),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort)
`ifdef ADC_SPI_EMULATOR_STATS_EN
        ,
        .done_count   (done_count),
        .abort_count  (abort_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  done_pulses  <= done_pulses + 1;
        if (frame_abort) abort_pulses <= abort_pulses + 1;
    end

    typedef struct {
        logic        load;
        logic [11:0] value;
        int          falls;
        logic [15:0] exp_word;
        int          exp_done;
        int          exp_abort;
    } vec_t;

    vec_t vecs [7];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mask_of(input int n);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < n && i < 16; i++) m[15-i] = 1'b1;
        return m;
    endfunction

    task automatic load(input logic [11:0] v);
        sample_value = v;
        sample_load  = 1'b1;
        cyc(1);
        sample_load  = 1'b0;
        hold_m       = v;
    endtask

    // One reader frame: bit k is sampled just before the k-th sclk fall.
    task automatic run_frame(input int nfalls, input int half, input logic load_at_fall,
                             input logic [11:0] lval, output logic [15:0] rx);
        rx = '0;
        cs = 1'b0;
        if (load_at_fall) begin
            cyc(2);
            sample_value = lval;
            sample_load  = 1'b1;
            cyc(1);
            sample_load  = 1'b0;
            cyc(half - 3);
        end else begin
            cyc(half);
        end
        for (int k = 0; k < nfalls; k++) begin
            rx[15-k] = sdo;
            if (k == 0) begin
                check("busy_in_frame", 32'(busy), 32'd1);
                check("oe_in_frame", 32'(sdo_oe), 32'd1);
            end
            sclk = 1'b0;
            cyc(half);
            sclk = 1'b1;
            cyc(half);
        end
        if (nfalls == 16) begin
            check("tail_sdo", 32'(sdo), 32'd0);
            check("tail_oe", 32'(sdo_oe), 32'd1);
        end
        cs = 1'b1;
        cyc(6);
    endtask

    task automatic end_checks(input string tag, input int d0, input int a0,
                              input int exp_d, input int exp_a);
        check({tag, "_done"}, 32'(done_pulses - d0), 32'(exp_d));
        check({tag, "_abort"}, 32'(abort_pulses - a0), 32'(exp_a));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_oe"}, 32'(sdo_oe), 32'd0);
        check({tag, "_sdo"}, 32'(sdo), 32'd0);
    endtask

    initial begin
        logic [15:0] rx;
        logic [15:0] m;
        int d0, a0, nf, hf;
        logic ld_mid;
        logic [11:0] v;

        reset = 1'b1; cs = 1'b1; sclk = 1'b1; sample_load = 1'b0; sample_value = '0;
        hold_m = '0;
        cyc(3);
        reset = 1'b0;
        cyc(2);
        check("rst_sdo", 32'(sdo), 32'd0);
        check("rst_oe", 32'(sdo_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_abort", 32'(frame_abort), 32'd0);

        // Holding register clears on reset: an unloaded frame serves zero.
        d0 = done_pulses; a0 = abort_pulses;
        run_frame(16, 5, 1'b0, 12'h0, rx);
        check("rst_hold_word", 32'(rx), 32'h0);
        end_checks("rst_frame", d0, a0, 1, 0);

        vecs[0] = '{1'b1, 12'hA5C, 16, 16'h0A5C, 1, 0};
        vecs[1] = '{1'b1, 12'hFFF, 16, 16'h0FFF, 1, 0};
        vecs[2] = '{1'b1, 12'h001, 16, 16'h0001, 1, 0};
        vecs[3] = '{1'b1, 12'h5A3,  7, 16'h05A3, 0, 1};
        vecs[4] = '{1'b0, 12'h000, 16, 16'h05A3, 1, 0};
        vecs[5] = '{1'b1, 12'h800, 15, 16'h0800, 1, 0};
        vecs[6] = '{1'b1, 12'hC31, 14, 16'h0C31, 0, 1};

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].load) load(vecs[i].value);
            cyc(3);
            d0 = done_pulses; a0 = abort_pulses;
            run_frame(vecs[i].falls, 5, 1'b0, 12'h0, rx);
            m = mask_of(vecs[i].falls);
            check($sformatf("vec%0d_word", i), 32'(rx & m), 32'(vecs[i].exp_word & m));
            end_checks($sformatf("vec%0d", i), d0, a0, vecs[i].exp_done, vecs[i].exp_abort);
        end

        // sdo follows a physical sclk fall by exactly three clk cycles.
        load(12'hA5C);
        d0 = done_pulses; a0 = abort_pulses;
        cs = 1'b0;
        cyc(5);
        for (int k = 0; k < 3; k++) begin
            sclk = 1'b0; cyc(5); sclk = 1'b1; cyc(5);
        end
        sclk = 1'b0;
        cyc(2);
        check("lat_before", 32'(sdo), 32'd0);
        cyc(1);
        check("lat_at", 32'(sdo), 32'd1);
        cyc(2);
        sclk = 1'b1;
        cyc(5);
        cs = 1'b1;
        cyc(6);
        end_checks("lat", d0, a0, 0, 1);

        // Load coinciding with cs fall: old value this frame, new value next.
        load(12'h3FF);
        cyc(3);
        d0 = done_pulses; a0 = abort_pulses;
        run_frame(16, 5, 1'b1, 12'h123, rx);
        check("coinc_word0", 32'(rx), 32'h03FF);
        end_checks("coinc0", d0, a0, 1, 0);
        hold_m = 12'h123;
        d0 = done_pulses; a0 = abort_pulses;
        run_frame(16, 5, 1'b0, 12'h0, rx);
        check("coinc_word1", 32'(rx), 32'h0123);
        end_checks("coinc1", d0, a0, 1, 0);

        // Reset after 9 sclk falls with cs still low.
        d0 = done_pulses; a0 = abort_pulses;
        cs = 1'b0;
        cyc(5);
        for (int k = 0; k < 9; k++) begin
            sclk = 1'b0; cyc(5); sclk = 1'b1; cyc(5);
        end
        reset = 1'b1;
        cyc(1);
        check("midrst_sdo", 32'(sdo), 32'd0);
        check("midrst_oe", 32'(sdo_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        hold_m = '0;
        cyc(8);
        check("midrst_no_restart", 32'(busy), 32'd0);
        cs = 1'b1;
        cyc(6);
        check("midrst_pulses", 32'((done_pulses - d0) + (abort_pulses - a0)), 32'd0);
        load(12'h6B9);
        d0 = done_pulses; a0 = abort_pulses;
        run_frame(16, 5, 1'b0, 12'h0, rx);
        check("midrst_word", 32'(rx), 32'h06B9);
        end_checks("midrst_next", d0, a0, 1, 0);

        // Random frames against the reference: word = {4'b0, holding}, done iff >= 15 falls.
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 1) == 1) load(12'($urandom));
            cyc($urandom_range(3, 9));
            nf = $urandom_range(0, 16);
            hf = $urandom_range(4, 7);
            ld_mid = 1'($urandom_range(0, 3) == 0);
            v = 12'($urandom);
            d0 = done_pulses; a0 = abort_pulses;
            run_frame(nf, hf, ld_mid, v, rx);
            m = mask_of(nf);
            check($sformatf("rnd%0d_word", i), 32'(rx & m), 32'({4'b0000, hold_m} & m));
            end_checks($sformatf("rnd%0d", i), d0, a0, (nf >= 15) ? 1 : 0, (nf >= 15) ? 0 : 1);
            if (ld_mid) hold_m = v;
        end

`ifdef ADC_SPI_EMULATOR_STATS_EN
        reset = 1'b1; cyc(2); reset = 1'b0; cyc(2);
        check("stats_rst_done", 32'(done_count), 32'd0);
        check("stats_rst_abort", 32'(abort_count), 32'd0);
        load(12'h0F0);
        for (int i = 0; i < 5; i++) begin
            run_frame((i % 2 == 1) ? 5 : 16, 5, 1'b0, 12'h0, rx);
        end
        check("stats_done", 32'(done_count), 32'd3);
        check("stats_abort", 32'(abort_count), 32'd2);
        reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
        check("stats_clr_done", 32'(done_count), 32'd0);
        check("stats_clr_abort", 32'(abort_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_emulator.md
Name: adc_spi_emulator

Overview:
- Synthesizable responder for the 3-wire serial ADC interface: it emulates the 12-bit serial ADC device on the other end of the ADC reader's cs/sclk/sdo link.
- It drives sdo from an internally held sample value, framed by the reader's cs and sclk.
- It is used for in-FPGA loopback of the ADC reader and for hardware-in-the-loop runs without a physical converter.
- cs and sclk are treated as asynchronous inputs and are oversampled in the clk domain.

Parameters:
- DATA_WIDTH, 12, number of sample bits shifted out, MSB first.
- LEAD_ZEROS, 4, number of leading zero bits before the MSB.
- SYNC_STAGES, 2, synchronizer flops on cs and sclk (minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_value  in  DATA_WIDTH  value to be served in the next frame.
- sample_load  in  1  one-cycle strobe; captures sample_value into the holding register.
- cs  in  1  chip select from the reader, active low, asynchronous.
- sclk  in  1  serial clock from the reader, asynchronous, idles high.
- sdo  out  1  serial data to the reader.
- sdo_oe  out  1  high while the emulator actively drives the frame (tri-state control for the pad).
- busy  out  1  high from cs fall until frame end or abort.
- frame_done  out  1  one-cycle pulse on a complete frame.
- frame_abort  out  1  one-cycle pulse on a short frame.

Behaviour:
- Reset values: sdo=0, sdo_oe=0, busy=0, frame_done=0, frame_abort=0, holding register=0, state=IDLE, bit counter=0.
- Synchronization and edges:
  - cs and sclk each pass through SYNC_STAGES flops, followed by one edge-detect register.
  - cs_fall, cs_rise and sclk_fall are single-cycle strobes.
  - Supported sclk frequency is at most clk/8.
- Holding register: loaded on sample_load in any state. The frame image latches at cs_fall, so a sample_load during a frame affects only the next frame.
- Frame length: FRAME_LEN = LEAD_ZEROS + DATA_WIDTH (16 at defaults).
- States:
  - IDLE: on cs_fall, latch shift register = {LEAD_ZEROS zeros, holding}; sdo = shift MSB (a leading zero); sdo_oe=1; busy=1; counter=0; go to SHIFT.
  - SHIFT: on each sclk_fall, shift left, present the next bit on sdo and increment the counter. When the counter reaches FRAME_LEN-1 on an sclk_fall, go to TAIL.
  - SHIFT, cs_rise before that point: pulse frame_abort, sdo_oe=0, sdo=0, busy=0, go to IDLE.
  - TAIL: the 16th sclk fall drives sdo=0 and keeps sdo_oe=1. On cs_rise: pulse frame_done, sdo_oe=0, busy=0, go to IDLE. Further sclk edges in TAIL hold sdo=0.
- Timing: sdo changes SYNC_STAGES+1 clk cycles after the physical sclk falling edge. This latency is fixed and has no jitter beyond one clk.
- Simultaneous events:
  - cs_rise and sclk_fall in the same cycle: cs_rise wins.
  - cs_fall while not IDLE cannot occur; cs must rise first.
  - sample_load and cs_fall in the same cycle: the frame uses the old holding value, and the new value is stored for the next frame.
- Reset mid-frame returns to IDLE with sdo_oe=0 immediately. The reader's cs must return high before the next frame is recognized: cs_fall is edge-detected, not level.
- Frames are counted MSB first. The bit at position k (0-based, counting from the cs-fall bit) equals frame image bit FRAME_LEN-1-k.

Optional Feature:
- Macro: ADC_SPI_EMULATOR_STATS_EN.
- Defined: adds outputs done_count[15:0] and abort_count[15:0]. Each saturates at 16'hFFFF, increments on frame_done / frame_abort respectively, and clears on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package adc_pkg:
  - ADC_DATA_WIDTH=12 and ADC_LEAD_ZEROS=4, shared with the ADC reader.
  - State enum {IDLE, SHIFT, TAIL}.
- Sub-module sync_edge: SYNC_STAGES-deep synchronizer plus rise/fall strobes. It is instantiated twice (cs, sclk) and is reusable by the reader.

Test Plan:
- sample_load 12'hA5C, full 16-clock frame at clk/10 → sdo bit sequence 0000_1010_0101_1100, frame_done single pulse after cs high, busy low, sdo_oe=0.
- Connect to the ADC reader with sample 12'hFFF, then 12'h001 → reader value reads 12'hFFF, then 12'h001.
- cs rises after 7 sclk falls → frame_abort pulse, no frame_done, next full frame serves the holding value correctly.
- sample_load 12'h123 on the same cycle as cs_fall with previous holding 12'h3FF → current frame shifts 12'h3FF, next frame shifts 12'h123.
- reset asserted after 9 sclk falls → sdo=0, sdo_oe=0, busy=0 next cycle; subsequent cs cycle serves a correct frame.
- With ADC_SPI_EMULATOR_STATS_EN: 3 full frames + 2 aborts → done_count=3, abort_count=2; reset → both 0.
